// File: rtl/clock_set_ctrl.sv
// Run/set controller for the clock datapath: button edge detection, field adjust pulses,
// blink phase and set-mode timeout. Define CLOCK_SET_AUTO_REPEAT_EN for press-and-hold auto-repeat.
module clock_set_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_1s,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable_cnt_h,
  output logic       enable_cnt_mi,
  output logic       enable_cnt_se,
  output logic       increase_h,
  output logic       decrease_h,
  output logic       increase_mi,
  output logic       decrease_mi,
  output logic       increase_se,
  output logic       decrease_se,
  output logic       blink_h,
  output logic       blink_mi,
  output logic       blink_se,
  output logic [1:0] set_mode
);
  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_MI = 2'd2, SET_SE = 2'd3} state_t;

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_S);

  state_t     state, state_nx;
  logic [2:0] btn_q, btn_prev;   // {mode, up, down}
  logic [7:0] tcnt, tcnt_nx;
  logic       phase, phase_nx;
  logic       in_set, both, mode_press, up_press, down_press, any_press;
  logic       adj_up, adj_dn, rep_fire, rep_up, inc_nx, dec_nx;
  logic [2:0] sel_nx;

  // Out-of-range configurations leave this marker block in the elaborated hierarchy.
  if (HOLD_CYCLES == 0 || REPEAT_CYCLES == 0 || TIMEOUT_S == 0 || TIMEOUT_S > 255) begin : g_bad_params
  end

  assign mode_press = btn_q[2] & ~btn_prev[2];
  assign up_press   = btn_q[1] & ~btn_prev[1];
  assign down_press = btn_q[0] & ~btn_prev[0];
  assign any_press  = |(btn_q & ~btn_prev);
  assign in_set     = (state != RUN);
  assign both       = btn_q[1] & btn_q[0];
  assign adj_up     = in_set & ~mode_press & ~both & up_press;
  assign adj_dn     = in_set & ~mode_press & ~both & down_press;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
  localparam logic [31:0] HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  logic [31:0] hcnt, hcnt_nx;
  logic        armed, armed_nx, dir_up, dir_up_nx, repeating, repeating_nx, hold_ok;

  // Only the button that produced the initial pulse keeps the hold alive; any mode press,
  // dual press or release disarms it until a fresh press.
  assign hold_ok = armed & in_set & ~mode_press & ~both & (dir_up ? btn_q[1] : btn_q[0]);

  always_comb begin
    hcnt_nx      = hcnt;
    armed_nx     = armed;
    dir_up_nx    = dir_up;
    repeating_nx = repeating;
    rep_fire     = 1'b0;
    if (adj_up | adj_dn) begin
      armed_nx     = 1'b1;
      dir_up_nx    = adj_up;
      hcnt_nx      = '0;
      repeating_nx = 1'b0;
    end else if (hold_ok) begin
      if (hcnt == (repeating ? REPEAT_LAST : HOLD_LAST)) begin
        rep_fire     = 1'b1;
        hcnt_nx      = '0;
        repeating_nx = 1'b1;
      end else begin
        hcnt_nx = hcnt + 32'd1;
      end
    end else begin
      armed_nx     = 1'b0;
      hcnt_nx      = '0;
      repeating_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      armed     <= 1'b0;
      dir_up    <= 1'b0;
      repeating <= 1'b0;
    end else begin
      hcnt      <= hcnt_nx;
      armed     <= armed_nx;
      dir_up    <= dir_up_nx;
      repeating <= repeating_nx;
    end
  end

  assign rep_up = rep_fire & dir_up;
`else
  assign rep_fire = 1'b0;
  assign rep_up   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    phase_nx = phase;
    if (mode_press) begin
      unique case (state)
        RUN:     state_nx = SET_H;
        SET_H:   state_nx = SET_MI;
        SET_MI:  state_nx = SET_SE;
        default: state_nx = RUN;
      endcase
    end else if (in_set && tcnt == TIMEOUT_VAL && !any_press && !rep_fire) begin
      state_nx = RUN;
    end

    if (any_press || rep_fire || state_nx == RUN) tcnt_nx = '0;
    else if (pulse_1s && tcnt != TIMEOUT_VAL)     tcnt_nx = tcnt + 8'd1;

    if (state_nx != state) phase_nx = 1'b0;
    else if (pulse_1s)     phase_nx = ~phase;

    inc_nx = adj_up | rep_up;
    dec_nx = adj_dn | (rep_fire & ~rep_up);

    unique case (state_nx)
      SET_H:   sel_nx = 3'b100;
      SET_MI:  sel_nx = 3'b010;
      SET_SE:  sel_nx = 3'b001;
      default: sel_nx = 3'b000;
    endcase
  end

  // Outputs are registered from next-state values so they move on the same edge as set_mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      btn_q         <= '0;
      btn_prev      <= '0;
      tcnt          <= '0;
      phase         <= 1'b0;
      set_mode      <= 2'd0;
      enable_cnt_h  <= 1'b1;
      enable_cnt_mi <= 1'b1;
      enable_cnt_se <= 1'b1;
      increase_h    <= 1'b0;
      increase_mi   <= 1'b0;
      increase_se   <= 1'b0;
      decrease_h    <= 1'b0;
      decrease_mi   <= 1'b0;
      decrease_se   <= 1'b0;
      blink_h       <= 1'b0;
      blink_mi      <= 1'b0;
      blink_se      <= 1'b0;
    end else begin
      state         <= state_nx;
      btn_q         <= {btn_mode, btn_up, btn_down};
      btn_prev      <= btn_q;
      tcnt          <= tcnt_nx;
      phase         <= phase_nx;
      set_mode      <= state_nx;
      enable_cnt_h  <= (state_nx == RUN);
      enable_cnt_mi <= (state_nx == RUN);
      enable_cnt_se <= (state_nx == RUN);
      increase_h    <= inc_nx & sel_nx[2];
      increase_mi   <= inc_nx & sel_nx[1];
      increase_se   <= inc_nx & sel_nx[0];
      decrease_h    <= dec_nx & sel_nx[2];
      decrease_mi   <= dec_nx & sel_nx[1];
      decrease_se   <= dec_nx & sel_nx[0];
      blink_h       <= phase_nx & sel_nx[2];
      blink_mi      <= phase_nx & sel_nx[1];
      blink_se      <= phase_nx & sel_nx[0];
    end
  end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed vector table, hand-written corner sequences
// and randomized stimulus against a behavioural model (honours CLOCK_SET_AUTO_REPEAT_EN).
module tb_clock_set_ctrl;
  localparam int HOLD    = 8;
  localparam int REPEAT  = 4;
  localparam int TIMEOUT = 3;

  // {set_mode[1:0], en{h,mi,se}, inc{h,mi,se}, dec{h,mi,se}, blink{h,mi,se}}
  localparam logic [13:0] O_RUN     = 14'b00_111_000_000_000;
  localparam logic [13:0] O_SH      = 14'b01_000_000_000_000;
  localparam logic [13:0] O_SMI     = 14'b10_000_000_000_000;
  localparam logic [13:0] O_SMI_INC = 14'b10_000_010_000_000;
  localparam logic [13:0] O_SSE     = 14'b11_000_000_000_000;

  logic clk = 1'b0;
  logic rst = 1'b1, pulse_1s = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic enable_cnt_h, enable_cnt_mi, enable_cnt_se;
  logic increase_h, decrease_h, increase_mi, decrease_mi, increase_se, decrease_se;
  logic blink_h, blink_mi, blink_se;
  logic [1:0] set_mode;
  logic [13:0] dut_out;

  always #5 clk = ~clk;

  clock_set_ctrl #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .TIMEOUT_S(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .pulse_1s(pulse_1s),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .enable_cnt_h(enable_cnt_h), .enable_cnt_mi(enable_cnt_mi), .enable_cnt_se(enable_cnt_se),
    .increase_h(increase_h), .decrease_h(decrease_h),
    .increase_mi(increase_mi), .decrease_mi(decrease_mi),
    .increase_se(increase_se), .decrease_se(decrease_se),
    .blink_h(blink_h), .blink_mi(blink_mi), .blink_se(blink_se),
    .set_mode(set_mode)
  );

  assign dut_out = {set_mode, enable_cnt_h, enable_cnt_mi, enable_cnt_se,
                    increase_h, increase_mi, increase_se,
                    decrease_h, decrease_mi, decrease_se,
                    blink_h, blink_mi, blink_se};

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, ncyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_state = 0;     // 0 RUN, 1 hours, 2 minutes, 3 seconds
  int   m_tcnt  = 0;     // seconds since last press while setting
  bit   m_phase = 0;
  bit   r1[3];           // button levels sampled at last edge (0 mode, 1 up, 2 down)
  bit   r2[3];           // and the edge before
  logic [13:0] m_out = O_RUN;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
  bit   m_armed = 0;
  int   m_dir   = 1;
  int   m_age   = 0;     // cycles since last pulse of the held button
  bit   m_rep   = 0;
`endif

  function automatic logic [13:0] pack_out(input int st, input bit ph, input bit inc, input bit dec);
    logic [2:0] sel;
    sel = (st == 1) ? 3'b100 : (st == 2) ? 3'b010 : (st == 3) ? 3'b001 : 3'b000;
    return {2'(st), (st == 0) ? 3'b111 : 3'b000, inc ? sel : 3'b000, dec ? sel : 3'b000,
            ph ? sel : 3'b000};
  endfunction

  task automatic model_edge(input bit r, input bit p, input bit bm, input bit bu, input bit bd);
    bit mp, upp, dnp, anyp, both, inset, inc, dec, fire;
    int ns;
    if (r) begin
      m_state = 0; m_tcnt = 0; m_phase = 0;
      r1 = '{0, 0, 0}; r2 = '{0, 0, 0};
`ifdef CLOCK_SET_AUTO_REPEAT_EN
      m_armed = 0; m_age = 0; m_rep = 0;
`endif
      m_out = pack_out(0, 0, 0, 0);
      return;
    end
    mp = r1[0] && !r2[0];
    upp = r1[1] && !r2[1];
    dnp = r1[2] && !r2[2];
    anyp = mp || upp || dnp;
    both = r1[1] && r1[2];
    inset = (m_state != 0);
    inc = 0; dec = 0; fire = 0;
    if (inset && !mp && !both) begin
      inc = upp;
      dec = dnp;
    end
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    if (inc || dec) begin
      m_armed = 1; m_dir = inc ? 1 : 2; m_age = 0; m_rep = 0;
    end else if (m_armed && inset && !mp && !both && r1[m_dir]) begin
      m_age++;
      if (m_age == (m_rep ? REPEAT : HOLD)) begin
        fire = 1; m_age = 0; m_rep = 1;
        if (m_dir == 1) inc = 1; else dec = 1;
      end
    end else begin
      m_armed = 0;
    end
`endif
    ns = m_state;
    if (mp) ns = (m_state + 1) % 4;
    else if (inset && m_tcnt >= TIMEOUT && !anyp && !fire) ns = 0;
    if (anyp || fire || ns == 0) m_tcnt = 0;
    else if (p && m_tcnt < TIMEOUT) m_tcnt++;
    if (ns != m_state) m_phase = 0;
    else if (p) m_phase = !m_phase;
    m_state = ns;
    m_out = pack_out(ns, m_phase, inc, dec);
    r2 = r1;
    r1[0] = bm; r1[1] = bu; r1[2] = bd;
  endtask

  // One clock: drive inputs, advance the model at the edge, compare #1 later.
  task automatic cyc(input bit m, input bit u, input bit d, input bit p, input bit r);
    btn_mode = m; btn_up = u; btn_down = d; pulse_1s = p; rst = r;
    @(posedge clk);
    model_edge(r, p, m, u, d);
    #1;
    ncyc++;
    check("model", 32'(dut_out), 32'(m_out));
  endtask

  task automatic tap_mode();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic tick_idle(input int unsigned n);
    cyc(0, 0, 0, 1, 0);
    for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit m, u, d, p, r;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int npulse;
    int rep_edges[$];
    int exp_edges[$];
    bit rm, ru, rd, rp, rr;

    tbl[0]  = '{0, 0, 0, 0, 1, O_RUN};
    tbl[1]  = '{0, 0, 0, 0, 0, O_RUN};
    tbl[2]  = '{0, 0, 0, 0, 0, O_RUN};
    tbl[3]  = '{0, 0, 0, 0, 0, O_RUN};
    tbl[4]  = '{1, 0, 0, 0, 0, O_RUN};
    tbl[5]  = '{0, 0, 0, 0, 0, O_SH};
    tbl[6]  = '{0, 0, 0, 0, 0, O_SH};
    tbl[7]  = '{1, 0, 0, 0, 0, O_SH};
    tbl[8]  = '{0, 0, 0, 0, 0, O_SMI};
    tbl[9]  = '{0, 0, 0, 0, 0, O_SMI};
    tbl[10] = '{0, 1, 0, 0, 0, O_SMI};
    tbl[11] = '{0, 0, 0, 0, 0, O_SMI_INC};
    tbl[12] = '{0, 0, 0, 0, 0, O_SMI};
    tbl[13] = '{1, 0, 0, 0, 0, O_SMI};
    tbl[14] = '{0, 0, 0, 0, 0, O_SSE};
    tbl[15] = '{1, 0, 0, 0, 0, O_SSE};
    tbl[16] = '{0, 0, 0, 0, 0, O_RUN};
    tbl[17] = '{0, 0, 0, 0, 0, O_RUN};

    // Reset then idle
    cyc(0, 0, 0, 0, 1);
    check("reset_out", 32'(dut_out), 32'(O_RUN));
    for (int unsigned i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    check("idle_out", 32'(dut_out), 32'(O_RUN));

    // Mode stepping and single up tap
    for (int unsigned i = 0; i < 18; i++) begin
      cyc(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].p, tbl[i].r);
      check($sformatf("tbl%0d", i), 32'(dut_out), 32'(tbl[i].exp));
    end

    // SET_H: up+down held together, then mode and up together
    tap_mode();
    check("enter_set_h", 32'(set_mode), 32'd1);
    npulse = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      cyc(0, 1, 1, 0, 0);
      npulse += int'(|dut_out[8:3]);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    npulse += int'(|dut_out[8:3]);
    check("both_held_pulses", 32'(npulse), 32'd0);
    npulse = 0;
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    npulse += int'(increase_h);
    cyc(0, 0, 0, 0, 0);
    npulse += int'(increase_h);
    check("mode_up_state", 32'(set_mode), 32'd2);
    check("mode_up_no_inc_h", 32'(npulse), 32'd0);

    // SET_SE: press-and-hold down, pulse edge offsets
    tap_mode();
    check("enter_set_se", 32'(set_mode), 32'd3);
    for (int k = 1; k <= 30; k++) begin
      cyc(0, 0, k <= 24, 0, 0);
      if (decrease_se) rep_edges.push_back(k);
    end
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    exp_edges = '{2, 10, 14, 18, 22};
`else
    exp_edges = '{2};
`endif
    check("hold_pulse_count", 32'(rep_edges.size()), 32'(exp_edges.size()));
    for (int unsigned i = 0; i < exp_edges.size() && i < rep_edges.size(); i++)
      check($sformatf("hold_pulse%0d_edge", i), 32'(rep_edges[i]), 32'(exp_edges[i]));
    tap_mode();
    check("back_to_run", 32'(dut_out), 32'(O_RUN));

    // Timeout with no presses, blink phase on ticks
    tap_mode();
    cyc(0, 0, 0, 1, 0);
    check("blink_after_tick1", 32'(blink_h), 32'd1);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("blink_after_tick2", 32'(blink_h), 32'd0);
    for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    check("before_timeout", 32'(set_mode), 32'd1);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("timeout_run", 32'(dut_out), 32'(O_RUN));

    // Timeout restarted by an up tap after the second tick
    tap_mode();
    tick_idle(3);
    tick_idle(3);
    npulse = 0;
    cyc(0, 1, 0, 0, 0);
    npulse += int'(increase_h);
    cyc(0, 0, 0, 0, 0);
    npulse += int'(increase_h);
    cyc(0, 0, 0, 0, 0);
    npulse += int'(increase_h);
    check("tap_inc_h", 32'(npulse), 32'd1);
    tick_idle(3);
    tick_idle(3);
    check("timeout_restarted", 32'(set_mode), 32'd1);
    tick_idle(1);
    check("timeout_after_restart", 32'(set_mode), 32'd0);

    // Reset mid-setting with up held
    tap_mode();
    tap_mode();
    check("enter_set_mi", 32'(set_mode), 32'd2);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    check("reset_mid_set", 32'(dut_out), 32'(O_RUN));
    npulse = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0, 0);
      npulse += int'(|dut_out[8:3]);
    end
    check("held_up_in_run", 32'(npulse), 32'd0);
    check("held_up_state", 32'(set_mode), 32'd0);
    cyc(0, 0, 0, 0, 0);

    // Randomized stimulus against the model
    rm = 0; ru = 0; rd = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) rm = !rm;
      if ($urandom_range(7) == 0)  ru = !ru;
      if ($urandom_range(7) == 0)  rd = !rd;
      rp = ($urandom_range(15) == 0);
      rr = ($urandom_range(599) == 0);
      cyc(rm, ru, rd, rp, rr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
